sti_feeder: RTL and testbench

Upstream stage of `STI_DAC`. Accepts parallel data words, each with its configuration word and a last-word flag, into a small FIFO. Presents one word at a time on the `STI_DAC` parallel-input port and issues a single-cycle `load`. Waits for the matching serial burst (`so_valid` high, then low) before loading the next word, and asserts `pi_end` with the final word.

---
 rtl/sti_pkg.sv | 14 +
 rtl/sti_feed_fifo.sv | 32 +++
 rtl/sti_feeder.sv | 113 +++++++++++
 tb/tb_sti_feeder.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/sti_pkg.sv
// sti_pkg: shared config bit positions, FSM states and FIFO entry layout for the STI_DAC feeder.
package sti_pkg;
  localparam int CFG_LEN_HI = 13;
  localparam int CFG_LEN_LO = 12;
  localparam int CFG_FILL   = 8;
  localparam int CFG_MSB    = 4;
  localparam int CFG_LOW    = 0;
  typedef enum logic [2:0] {IDLE, LOAD, WAIT_START, WAIT_END, GAP} state_t;
  typedef struct packed {
    logic        last;
    logic [15:0] cfg;
    logic [15:0] data;
  } fifo_entry_t;
endpackage

// File: rtl/sti_feed_fifo.sv
// sti_feed_fifo: synchronous FIFO with wrap-bit pointers; read data is the head entry, shown combinationally.
module sti_feed_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 33
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_wdata,
  output logic [W-1:0] o_rdata,
  output logic         o_full,
  output logic         o_empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wptr;
  logic [AW:0]  r_rptr;
  assign o_empty = r_wptr == r_rptr;
  assign o_full  = r_wptr == {~r_rptr[AW], r_rptr[AW-1:0]};
  assign o_rdata = r_mem[r_rptr[AW-1:0]];
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + (AW+1)'(1);
      if (i_pop) r_rptr <= r_rptr + (AW+1)'(1);
    end
  always_ff @(posedge clk)
    if (i_push) r_mem[r_wptr[AW-1:0]] <= i_wdata;
endmodule

// File: rtl/sti_feeder.sv
// sti_feeder: buffers words for STI_DAC, issues one load per word and waits for its serial burst.
module sti_feeder import sti_pkg::*; #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  input  logic [15:0] in_cfg,
  input  logic        in_last,
  output logic        load,
  output logic [15:0] pi_data,
  output logic [1:0]  pi_length,
  output logic        pi_fill,
  output logic        pi_msb,
  output logic        pi_low,
  output logic        pi_end,
  input  logic        so_valid,
  output logic        busy,
  output logic [7:0]  word_cnt,
  output logic        timeout_err
);
  localparam int TW = $clog2(TIMEOUT);
  state_t      r_state;
  logic [TW-1:0] r_tmr;
  logic        r_load;
  logic [15:0] r_pi_data;
  logic [1:0]  r_pi_length;
  logic        r_pi_fill;
  logic        r_pi_msb;
  logic        r_pi_low;
  logic        r_pi_end;
  logic [7:0]  r_word_cnt;
  logic        r_timeout_err;
  fifo_entry_t w_wr;
  fifo_entry_t w_rd;
  logic        w_full;
  logic        w_empty;
  logic        w_push;
  logic        w_pop;
  logic        w_unused;
  assign w_wr     = {in_last, in_cfg, in_data};
  assign w_push   = in_valid && !w_full;
  assign w_pop    = r_state == IDLE && !w_empty && !r_pi_end;
  assign w_unused = &{1'b0, w_rd.cfg};
  sti_feed_fifo #(.DEPTH(DEPTH), .W($bits(fifo_entry_t))) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata (w_wr),
    .o_rdata (w_rd),
    .o_full  (w_full),
    .o_empty (w_empty)
  );
  // load and pi_* are captured on the pop edge so they are valid for the whole LOAD cycle
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_state       <= IDLE;
      r_tmr         <= '0;
      r_load        <= 1'b0;
      r_pi_data     <= '0;
      r_pi_length   <= '0;
      r_pi_fill     <= 1'b0;
      r_pi_msb      <= 1'b0;
      r_pi_low      <= 1'b0;
      r_pi_end      <= 1'b0;
      r_word_cnt    <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_load <= 1'b0;
      case (r_state)
        IDLE: if (w_pop) begin
          r_state     <= LOAD;
          r_load      <= 1'b1;
          r_pi_data   <= w_rd.data;
          r_pi_length <= w_rd.cfg[CFG_LEN_HI:CFG_LEN_LO];
          r_pi_fill   <= w_rd.cfg[CFG_FILL];
          r_pi_msb    <= w_rd.cfg[CFG_MSB];
          r_pi_low    <= w_rd.cfg[CFG_LOW];
          r_pi_end    <= w_rd.last;
        end
        LOAD: begin
          r_state <= WAIT_START;
          r_tmr   <= '0;
        end
        WAIT_START:
          if (so_valid) r_state <= WAIT_END;
          else if (r_tmr == TW'(TIMEOUT-1)) begin
            r_timeout_err <= 1'b1;
            r_state       <= GAP;
          end else r_tmr <= r_tmr + TW'(1);
        WAIT_END: if (!so_valid) begin
          r_word_cnt <= r_word_cnt + 8'd1;
          r_state    <= GAP;
        end
        default: r_state <= IDLE;
      endcase
    end
  assign in_ready    = !w_full;
  assign busy        = r_state != IDLE || !w_empty;
  assign load        = r_load;
  assign pi_data     = r_pi_data;
  assign pi_length   = r_pi_length;
  assign pi_fill     = r_pi_fill;
  assign pi_msb      = r_pi_msb;
  assign pi_low      = r_pi_low;
  assign pi_end      = r_pi_end;
  assign word_cnt    = r_word_cnt;
  assign timeout_err = r_timeout_err;
endmodule

// File: tb/tb_sti_feeder.sv
// tb_sti_feeder: directed vectors and multi-cycle sequences against hand-computed expectations.
module tb_sti_feeder;
  localparam int TO = 16;
  typedef struct {
    logic [15:0] d;
    logic [15:0] c;
    logic        l;
    logic [1:0]  elen;
    logic        ef;
    logic        em;
    logic        el;
  } vec_t;
  logic clk = 1'b0;
  logic reset, in_valid, in_ready, in_last, load, pi_fill, pi_msb, pi_low, pi_end, so_valid, busy, timeout_err;
  logic [15:0] in_data, in_cfg, pi_data;
  logic [1:0] pi_length;
  logic [7:0] word_cnt;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  sti_feeder #(.DEPTH(4), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_cfg(in_cfg), .in_last(in_last), .load(load),
    .pi_data(pi_data), .pi_length(pi_length), .pi_fill(pi_fill), .pi_msb(pi_msb),
    .pi_low(pi_low), .pi_end(pi_end), .so_valid(so_valid), .busy(busy),
    .word_cnt(word_cnt), .timeout_err(timeout_err)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic chk_reset_vals(input string tag);
    chk({tag, "_load"}, load, 0);
    chk({tag, "_pi"}, {pi_data, pi_length, pi_fill, pi_msb, pi_low}, 0);
    chk({tag, "_end"}, pi_end, 0);
    chk({tag, "_cnt"}, word_cnt, 0);
    chk({tag, "_err"}, timeout_err, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_ready"}, in_ready, 1);
  endtask
  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask
  task automatic push(input logic [15:0] d, input logic [15:0] c, input logic l);
    chk("push_ready", in_ready, 1);
    in_valid = 1'b1; in_data = d; in_cfg = c; in_last = l;
    @(negedge clk);
    in_valid = 1'b0;
  endtask
  task automatic wait_load(input int max, output int n);
    int i = 0;
    n = 0;
    while (n == 0 && i < max) begin
      @(negedge clk);
      i++;
      if (load) n = i;
    end
  endtask
  task automatic burst(input int len);
    @(negedge clk);
    so_valid = 1'b1;
    repeat (len) @(negedge clk);
    so_valid = 1'b0;
  endtask
  vec_t v[5];
  int n;
  int miss;
  initial begin
    v[0] = '{16'h1111, 16'h3000, 1'b0, 2'd3, 1'b0, 1'b0, 1'b0};
    v[1] = '{16'h2222, 16'h0111, 1'b0, 2'd0, 1'b1, 1'b1, 1'b1};
    v[2] = '{16'h3333, 16'hC010, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0};
    v[3] = '{16'h4444, 16'h1101, 1'b0, 2'd1, 1'b1, 1'b0, 1'b1};
    v[4] = '{16'h5555, 16'hFFFF, 1'b0, 2'd3, 1'b1, 1'b1, 1'b1};
    in_valid = 0; in_data = 0; in_cfg = 0; in_last = 0; so_valid = 0;
    do_reset();
    chk_reset_vals("rst");
    // single word with last flag
    push(16'hA5C3, 16'h2111, 1'b1);
    chk("single_noload_early", load, 0);
    wait_load(5, n);
    chk("single_latency", n, 1);
    chk("single_data", pi_data, 16'hA5C3);
    chk("single_cfg", {pi_length, pi_fill, pi_msb, pi_low}, 5'b10111);
    chk("single_end", pi_end, 1);
    burst(8);
    chk("single_cnt_pre", word_cnt, 0);
    @(negedge clk);
    chk("single_cnt", word_cnt, 1);
    chk("single_busy_gap", busy, 1);
    @(negedge clk);
    chk("single_idle", busy, 0);
    do_reset();
    // back-to-back table; first word is loaded while later pushes are still arriving
    for (int i = 0; i < 5; i++) push(v[i].d, v[i].c, v[i].l);
    chk("b2b_full", in_ready, 0);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin
        wait_load(8, n);
        chk("b2b_latency", n, 3);
      end
      chk("b2b_data", pi_data, v[i].d);
      chk("b2b_cfg", {pi_length, pi_fill, pi_msb, pi_low}, {v[i].elen, v[i].ef, v[i].em, v[i].el});
      chk("b2b_end", pi_end, 0);
      burst(3);
    end
    @(negedge clk);
    chk("b2b_cnt", word_cnt, 5);
    chk("b2b_ready", in_ready, 1);
    // timeout with a second word queued during the wait
    push(16'h6666, 16'h0000, 1'b0);
    wait_load(5, n);
    chk("to_load", n, 1);
    for (int k = 1; k <= TO + 1; k++) begin
      @(negedge clk);
      if (k == 2) begin in_valid = 1; in_data = 16'h7777; in_cfg = 16'h1010; in_last = 0; end
      if (k == 3) in_valid = 0;
      if (k == TO) chk("to_early", timeout_err, 0);
    end
    chk("to_set", timeout_err, 1);
    chk("to_cnt", word_cnt, 5);
    wait_load(8, n);
    chk("to_next_latency", n, 2);
    chk("to_next_data", pi_data, 16'h7777);
    chk("to_next_cfg", {pi_length, pi_fill, pi_msb, pi_low}, 5'b01010);
    burst(2);
    @(negedge clk);
    chk("to_next_cnt", word_cnt, 6);
    chk("to_sticky", timeout_err, 1);
    // reset asserted mid-burst with so_valid still high
    do_reset();
    push(16'h8888, 16'h3111, 1'b0);
    wait_load(5, n);
    chk("mid_load", n, 1);
    @(negedge clk);
    so_valid = 1'b1;
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1 chk_reset_vals("mid_async");
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    so_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_cnt", word_cnt, 0);
    chk("mid_busy", busy, 0);
    // end stop: last flag on the second of three words
    push(16'h0A0A, 16'h0000, 1'b0);
    push(16'h0B0B, 16'h0000, 1'b1);
    push(16'h0C0C, 16'h0000, 1'b0);
    chk("es_first", pi_data, 16'h0A0A);
    chk("es_first_end", pi_end, 0);
    burst(2);
    wait_load(8, n);
    chk("es_second", n, 3);
    chk("es_second_data", pi_data, 16'h0B0B);
    chk("es_second_end", pi_end, 1);
    burst(2);
    wait_load(20, n);
    chk("es_no_third", n, 0);
    chk("es_end_sticky", pi_end, 1);
    chk("es_busy", busy, 1);
    chk("es_data_hold", pi_data, 16'h0B0B);
    chk("es_cnt", word_cnt, 2);
    // word counter wrap
    do_reset();
    miss = 0;
    for (int i = 0; i < 256; i++) begin
      push(16'(i), 16'h0000, 1'b0);
      if (i == 255) chk("wrap_255", word_cnt, 8'hFF);
      wait_load(8, n);
      if (n == 0) miss++;
      burst(1);
    end
    @(negedge clk);
    chk("wrap_missed", miss, 0);
    chk("wrap_zero", word_cnt, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
